// File: rtl/ddp_rx_parse_pkg.sv
// Shared definitions for the DDP receive parser: header layout, FSM encodings, error codes.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package ddp_rx_parse_pkg;

    localparam int DDP_DATA_W     = 256;
    localparam int DDP_QUEUES     = 4;
    localparam int BYTES_PER_WORD = 32;
    localparam int BPW_SHIFT      = 5;    // log2(BYTES_PER_WORD)

    // Header word field offsets and widths
    localparam int DDP_CTRL_LSB   = 0;
    localparam int DDP_CTRL_W     = 8;
    localparam int RDMAP_CTRL_LSB = 8;
    localparam int RDMAP_CTRL_W   = 8;
    localparam int RDMAP_HDR_LSB  = 16;
    localparam int RDMAP_HDR_W    = 56;
    localparam int LEN_LSB        = 72;
    localparam int LEN_W          = 16;
    localparam int QIDX_LSB       = 88;
    localparam int QIDX_W         = 4;
    localparam int HDR_USED_W     = 92;   // bits above this are ignored
    localparam int WL_W           = 12;   // payload word down-counter width

    // Packed view of header word bits [91:0], MSB field first
    typedef struct packed {
        logic [QIDX_W-1:0]       qidx;
        logic [LEN_W-1:0]        len;
        logic [RDMAP_HDR_W-1:0]  rdmap_hdr;
        logic [RDMAP_CTRL_W-1:0] rdmap_ctrl;
        logic [DDP_CTRL_W-1:0]   ddp_ctrl;
    } hdr_t;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_PAYLOAD = 2'd1;
    localparam logic [1:0] ST_DROP    = 2'd2;

    localparam logic [1:0] ERR_LEN   = 2'd1;
    localparam logic [1:0] ERR_SOP   = 2'd2;
    localparam logic [1:0] ERR_QUEUE = 2'd3;

    // ceil(len/32) on the length already truncated modulo 4096
    function automatic logic [WL_W-1:0] words_for_len(input logic [WL_W-1:0] len);
        logic [WL_W:0] sum;
        sum = {1'b0, len} + (WL_W+1)'(BYTES_PER_WORD - 1);
        return WL_W'(sum >> BPW_SHIFT);
    endfunction

endpackage

// File: rtl/ddp_rx_parse_hdr_slot.sv
// Single-entry holding register for the RDMAP header of the last good segment.
// Latency: load visible 1 cycle after load_i; valid clears 1 cycle after ready_i is sampled high.
// Backpressure: data held stable while valid_o && !ready_i; the parent stops new loads while valid.
// Ports: clk/rst_n, load_i + hdr_i/ctrl_i (fill), ready_i (consume), valid_o/hdr_o/ctrl_o (slot).
module ddp_rx_parse_hdr_slot
    import ddp_rx_parse_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load_i,
    input  logic [RDMAP_HDR_W-1:0]  hdr_i,
    input  logic [RDMAP_CTRL_W-1:0] ctrl_i,
    input  logic                    ready_i,
    output logic                    valid_o,
    output logic [RDMAP_HDR_W-1:0]  hdr_o,
    output logic [RDMAP_CTRL_W-1:0] ctrl_o
);

    logic                    vld_q, vld_d;
    logic [RDMAP_HDR_W-1:0]  hdr_q, hdr_d;
    logic [RDMAP_CTRL_W-1:0] ctrl_q, ctrl_d;

    always_comb begin
        vld_d  = vld_q;
        hdr_d  = hdr_q;
        ctrl_d = ctrl_q;
        if (load_i) begin
            vld_d  = 1'b1;
            hdr_d  = hdr_i;
            ctrl_d = ctrl_i;
        end else if (vld_q && ready_i) begin
            vld_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q  <= 1'b0;
            hdr_q  <= '0;
            ctrl_q <= '0;
        end else begin
            vld_q  <= vld_d;
            hdr_q  <= hdr_d;
            ctrl_q <= ctrl_d;
        end
    end

    assign valid_o = vld_q;
    assign hdr_o   = hdr_q;
    assign ctrl_o  = ctrl_q;

endmodule

// File: rtl/ddp_rx_parse.sv
// DDP segment parser: header decode, payload steering to one of QUEUES queues, error reporting.
// Latency: payload push 1 cycle after word accept; header slot / error / segment count 1 cycle after last word.
// Backpressure: rx_ready_o low while the header slot is occupied (IDLE) or the target queue is full (PAYLOAD).
// Ports: rx_* segment stream in, queue_full_i, push_* payload out, ddp2rdmap_* header slot,
//        err_* error pulse, seg_cnt_o good-segment count with seg_cnt_ld_* preload.
module ddp_rx_parse
    import ddp_rx_parse_pkg::*;
#(
    parameter int DATA_W = DDP_DATA_W,
    parameter int QUEUES = DDP_QUEUES
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [DATA_W-1:0]       rx_data_i,
    input  logic                    rx_valid_i,
    input  logic                    rx_sop_i,
    input  logic                    rx_eop_i,
    output logic                    rx_ready_o,
    input  logic [QUEUES-1:0]       queue_full_i,
    output logic                    push_o,
    output logic [DATA_W-1:0]       push_data_o,
    output logic [QUEUES-1:0]       qn_o,
    output logic                    ddp2rdmap_hdr_valid_o,
    output logic [RDMAP_HDR_W-1:0]  ddp2rdmap_header_o,
    output logic [RDMAP_CTRL_W-1:0] ddp2rdmap_control_o,
    input  logic                    rdmap_hdr_ready_i,
    output logic                    err_valid_o,
    output logic [1:0]              err_code_o,
    output logic [15:0]             seg_cnt_o,
    input  logic                    seg_cnt_ld_i,
    input  logic [15:0]             seg_cnt_ld_dat_i
);

    localparam int              QI_W     = (QUEUES > 1) ? $clog2(QUEUES) : 1;
    localparam logic [QIDX_W-1:0] QUEUES_L = QIDX_W'(QUEUES);

    logic [1:0]              state_q, state_d;
    logic [QI_W-1:0]         qidx_q, qidx_d;
    logic [WL_W-1:0]         wl_q, wl_d;
    logic [RDMAP_HDR_W-1:0]  rhdr_q, rhdr_d;
    logic [RDMAP_CTRL_W-1:0] rctrl_q, rctrl_d;
    logic                    run_q;
    logic                    push_q, push_d;
    logic [DATA_W-1:0]       push_data_q, push_data_d;
    logic [QUEUES-1:0]       qn_q, qn_d;
    logic                    err_vld_q, err_vld_d;
    logic [1:0]              err_code_q, err_code_d;
    logic [15:0]             seg_cnt_q;

    logic                    good;
    logic [RDMAP_HDR_W-1:0]  slot_hdr;
    logic [RDMAP_CTRL_W-1:0] slot_ctrl;
    logic                    slot_vld;
    logic                    rdy;
    logic                    xfer;
    hdr_t                    hdr;
    logic [WL_W-1:0]         len12;
    logic                    unused_ok;

    assign hdr       = hdr_t'(rx_data_i[HDR_USED_W-1:0]);
    assign len12     = hdr.len[WL_W-1:0];
    assign unused_ok = ^{rx_data_i[DATA_W-1:HDR_USED_W], hdr.ddp_ctrl, hdr.len[LEN_W-1:WL_W]};

    // run_q keeps rx_ready_o low during reset and for the first cycle after release,
    // so ready never depends combinationally on the reset pin.
    always_comb begin
        rdy = 1'b0;
        if (run_q) begin
            case (state_q)
                ST_IDLE:    rdy = !slot_vld;
                ST_PAYLOAD: rdy = !queue_full_i[qidx_q];
                ST_DROP:    rdy = 1'b1;
                default:    rdy = 1'b0;
            endcase
        end
    end

    assign rx_ready_o = rdy;
    assign xfer       = rx_valid_i && rdy;

    always_comb begin
        state_d     = state_q;
        qidx_d      = qidx_q;
        wl_d        = wl_q;
        rhdr_d      = rhdr_q;
        rctrl_d     = rctrl_q;
        push_d      = 1'b0;
        push_data_d = push_data_q;
        qn_d        = qn_q;
        err_vld_d   = 1'b0;
        err_code_d  = err_code_q;
        good        = 1'b0;
        slot_hdr    = rhdr_q;
        slot_ctrl   = rctrl_q;
        case (state_q)
            ST_IDLE: begin
                // non-sop words in IDLE are swallowed without a report
                if (xfer && rx_sop_i) begin
                    rhdr_d  = hdr.rdmap_hdr;
                    rctrl_d = hdr.rdmap_ctrl;
                    qidx_d  = hdr.qidx[QI_W-1:0];
                    wl_d    = words_for_len(len12);
                    if (hdr.qidx >= QUEUES_L) begin
                        err_vld_d  = 1'b1;
                        err_code_d = ERR_QUEUE;
                        state_d    = rx_eop_i ? ST_IDLE : ST_DROP;
                    end else if (len12 == '0) begin
                        if (rx_eop_i) begin
                            // header-only segment completes here; slot fed straight from the wire
                            good      = 1'b1;
                            slot_hdr  = hdr.rdmap_hdr;
                            slot_ctrl = hdr.rdmap_ctrl;
                        end else begin
                            err_vld_d  = 1'b1;
                            err_code_d = ERR_LEN;
                            state_d    = ST_DROP;
                        end
                    end else if (rx_eop_i) begin
                        err_vld_d  = 1'b1;
                        err_code_d = ERR_LEN;
                    end else begin
                        state_d = ST_PAYLOAD;
                    end
                end
            end
            ST_PAYLOAD: begin
                if (xfer) begin
                    if (rx_sop_i) begin
                        err_vld_d  = 1'b1;
                        err_code_d = ERR_SOP;
                        state_d    = rx_eop_i ? ST_IDLE : ST_DROP;
                    end else begin
                        push_d      = 1'b1;
                        push_data_d = rx_data_i;
                        qn_d        = {{(QUEUES-1){1'b0}}, 1'b1} << qidx_q;
                        wl_d        = wl_q - 1'b1;
                        if (wl_q == WL_W'(1)) begin
                            if (rx_eop_i) begin
                                good    = 1'b1;
                                state_d = ST_IDLE;
                            end else begin
                                err_vld_d  = 1'b1;
                                err_code_d = ERR_LEN;
                                state_d    = ST_DROP;
                            end
                        end else if (rx_eop_i) begin
                            // short segment: already-pushed words stay pushed
                            err_vld_d  = 1'b1;
                            err_code_d = ERR_LEN;
                            state_d    = ST_IDLE;
                        end
                    end
                end
            end
            ST_DROP: begin
                if (xfer && rx_eop_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            qidx_q      <= '0;
            wl_q        <= '0;
            rhdr_q      <= '0;
            rctrl_q     <= '0;
            run_q       <= 1'b0;
            push_q      <= 1'b0;
            push_data_q <= '0;
            qn_q        <= '0;
            err_vld_q   <= 1'b0;
            err_code_q  <= '0;
            seg_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            qidx_q      <= qidx_d;
            wl_q        <= wl_d;
            rhdr_q      <= rhdr_d;
            rctrl_q     <= rctrl_d;
            run_q       <= 1'b1;
            push_q      <= push_d;
            push_data_q <= push_data_d;
            qn_q        <= qn_d;
            err_vld_q   <= err_vld_d;
            err_code_q  <= err_code_d;
            if (seg_cnt_ld_i) begin
                seg_cnt_q <= seg_cnt_ld_dat_i;
            end else if (good) begin
                seg_cnt_q <= seg_cnt_q + 16'd1;
            end
        end
    end

    ddp_rx_parse_hdr_slot u_hdr_slot (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (good),
        .hdr_i   (slot_hdr),
        .ctrl_i  (slot_ctrl),
        .ready_i (rdmap_hdr_ready_i),
        .valid_o (slot_vld),
        .hdr_o   (ddp2rdmap_header_o),
        .ctrl_o  (ddp2rdmap_control_o)
    );

    assign ddp2rdmap_hdr_valid_o = slot_vld;
    assign push_o                = push_q;
    assign push_data_o           = push_data_q;
    assign qn_o                  = qn_q;
    assign err_valid_o           = err_vld_q;
    assign err_code_o            = err_code_q;
    assign seg_cnt_o             = seg_cnt_q;

endmodule

// File: tb/tb_ddp_rx_parse.sv
// Directed bench for ddp_rx_parse with a scoreboard of expected pushes, errors and headers.
// Latency: n/a.
// Backpressure: exercises queue-full stalls and header-slot backpressure.
module tb_ddp_rx_parse;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [255:0] rx_data;
    logic         rx_valid, rx_sop, rx_eop, rx_ready;
    logic [3:0]   queue_full;
    logic         push;
    logic [255:0] push_data;
    logic [3:0]   qn;
    logic         hdr_valid;
    logic [55:0]  hdr_out;
    logic [7:0]   ctrl_out;
    logic         rdmap_ready;
    logic         err_valid;
    logic [1:0]   err_code;
    logic [15:0]  seg_cnt;
    logic         seg_ld;
    logic [15:0]  seg_ld_dat;

    always #5 clk = ~clk;

    ddp_rx_parse dut (
        .clk                   (clk),
        .rst_n                 (rst_n),
        .rx_data_i             (rx_data),
        .rx_valid_i            (rx_valid),
        .rx_sop_i              (rx_sop),
        .rx_eop_i              (rx_eop),
        .rx_ready_o            (rx_ready),
        .queue_full_i          (queue_full),
        .push_o                (push),
        .push_data_o           (push_data),
        .qn_o                  (qn),
        .ddp2rdmap_hdr_valid_o (hdr_valid),
        .ddp2rdmap_header_o    (hdr_out),
        .ddp2rdmap_control_o   (ctrl_out),
        .rdmap_hdr_ready_i     (rdmap_ready),
        .err_valid_o           (err_valid),
        .err_code_o            (err_code),
        .seg_cnt_o             (seg_cnt),
        .seg_cnt_ld_i          (seg_ld),
        .seg_cnt_ld_dat_i      (seg_ld_dat)
    );

    typedef struct { logic [255:0] dat; logic [3:0] qn; } push_t;
    typedef struct { logic [55:0] h; logic [7:0] c; } hexp_t;

    push_t       exp_push[$];
    hexp_t       exp_hdr[$];
    logic [1:0]  exp_err[$];
    logic [15:0] exp_seg;
    int          checks   = 0;
    int          failures = 0;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [255:0] rnd256();
        logic [255:0] w;
        for (int i = 0; i < 8; i++) w[i*32 +: 32] = $urandom();
        return w;
    endfunction

    function automatic logic [255:0] mk_hdr(input logic [3:0] q, input logic [15:0] len,
                                            input logic [55:0] rh, input logic [7:0] rc);
        logic [255:0] w;
        w        = rnd256();
        w[91:88] = q;
        w[87:72] = len;
        w[71:16] = rh;
        w[15:8]  = rc;
        return w;
    endfunction

    task automatic start_word(input logic [255:0] d, input logic sop, input logic eop);
        @(negedge clk);
        #1;
        rx_data  = d;
        rx_valid = 1'b1;
        rx_sop   = sop;
        rx_eop   = eop;
    endtask

    task automatic finish_word();
        int n;
        n = 0;
        #1;
        while (!rx_ready && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (n >= 100) chk("xfer_timeout", rx_ready, 1'b1);
        @(posedge clk);
    endtask

    task automatic send_word(input logic [255:0] d, input logic sop, input logic eop);
        start_word(d, sop, eop);
        finish_word();
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        #1;
        rx_valid = 1'b0;
        rx_sop   = 1'b0;
        rx_eop   = 1'b0;
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic send_hdr(input logic [3:0] q, input logic [15:0] len, input logic eop,
                            input logic [55:0] rh, input logic [7:0] rc);
        send_word(mk_hdr(q, len, rh, rc), 1'b1, eop);
    endtask

    // n payload words to queue q, each expected as a push; eop on the last if eop_last
    task automatic send_pay(input logic [3:0] q, input int n, input logic eop_last);
        logic [255:0] d;
        for (int i = 1; i <= n; i++) begin
            d = rnd256();
            exp_push.push_back('{d, 4'b0001 << q});
            send_word(d, 1'b0, eop_last && (i == n));
        end
    endtask

    // scoreboard monitor, sampling registered outputs away from the rising edge
    logic prev_vld = 1'b0;
    always @(negedge clk) begin
        push_t p;
        hexp_t h;
        logic [1:0] e;
        if (!rst_n) begin
            prev_vld = 1'b0;
        end else begin
            if (push) begin
                if (exp_push.size() == 0) chk("push_unexpected", push, 1'b0);
                else begin
                    p = exp_push.pop_front();
                    chk("push_data", push_data, p.dat);
                    chk("push_qn", qn, p.qn);
                end
            end
            if (err_valid) begin
                if (exp_err.size() == 0) chk("err_unexpected", err_valid, 1'b0);
                else begin
                    e = exp_err.pop_front();
                    chk("err_code", err_code, e);
                end
            end
            if (hdr_valid && !prev_vld) begin
                if (exp_hdr.size() == 0) chk("hdr_unexpected", hdr_valid, 1'b0);
                else begin
                    h = exp_hdr.pop_front();
                    chk("hdr_data", hdr_out, h.h);
                    chk("hdr_ctrl", ctrl_out, h.c);
                end
            end
            prev_vld = hdr_valid;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [55:0]  rh, rh_a, rh_b;
        logic [7:0]   rc, rc_a, rc_b;
        logic [255:0] d2;
        int           low;

        rst_n = 1'b0; rx_data = '0; rx_valid = 1'b0; rx_sop = 1'b0; rx_eop = 1'b0;
        queue_full = '0; rdmap_ready = 1'b1; seg_ld = 1'b0; seg_ld_dat = '0;
        exp_seg = '0;

        // reset state
        repeat (3) @(negedge clk);
        #1;
        chk("rst_rx_ready", rx_ready, 1'b0);
        chk("rst_push", push, 1'b0);
        chk("rst_push_data", push_data, '0);
        chk("rst_qn", qn, '0);
        chk("rst_hdr_valid", hdr_valid, 1'b0);
        chk("rst_hdr", {ctrl_out, hdr_out}, '0);
        chk("rst_err", {err_valid, err_code}, '0);
        chk("rst_seg_cnt", seg_cnt, '0);
        rst_n = 1'b1;
        idle(2);

        // good segment: len 64, q 2, two words
        rh = {$urandom(), 24'($urandom())}; rc = 8'($urandom());
        exp_hdr.push_back('{rh, rc}); exp_seg++;
        send_hdr(4'd2, 16'd64, 1'b0, rh, rc);
        send_pay(4'd2, 2, 1'b1);
        idle(3);
        chk("seg_cnt_first", seg_cnt, exp_seg);

        // same segment with queue 2 full for 5 cycles mid-payload
        rh = {$urandom(), 24'($urandom())}; rc = 8'($urandom());
        exp_hdr.push_back('{rh, rc}); exp_seg++;
        send_hdr(4'd2, 16'd64, 1'b0, rh, rc);
        send_pay(4'd2, 1, 1'b0);
        d2 = rnd256();
        exp_push.push_back('{d2, 4'b0100});
        start_word(d2, 1'b0, 1'b1);
        queue_full = 4'b0100;
        #1;
        low = 0;
        for (int i = 0; i < 5; i++) begin
            if (!rx_ready) low++;
            @(negedge clk);
            #1;
        end
        queue_full = '0;
        chk("stall_low_cycles", low, 5);
        finish_word();
        idle(3);
        chk("seg_cnt_stall", seg_cnt, exp_seg);

        // len 96 but eop on second payload word
        exp_err.push_back(2'd1);
        send_hdr(4'd1, 16'd96, 1'b0, 56'h1, 8'h1);
        send_pay(4'd1, 2, 1'b1);
        idle(3);
        chk("seg_cnt_short", seg_cnt, exp_seg);
        chk("hdr_valid_short", hdr_valid, 1'b0);

        // sop inside payload, drop to eop, then a good segment
        exp_err.push_back(2'd2);
        send_hdr(4'd1, 16'd64, 1'b0, 56'h2, 8'h2);
        send_word(rnd256(), 1'b1, 1'b0);
        send_word(rnd256(), 1'b0, 1'b0);
        send_word(rnd256(), 1'b0, 1'b1);
        rh = {$urandom(), 24'($urandom())}; rc = 8'($urandom());
        exp_hdr.push_back('{rh, rc}); exp_seg++;
        send_hdr(4'd3, 16'd32, 1'b0, rh, rc);
        send_pay(4'd3, 1, 1'b1);
        idle(3);
        chk("seg_cnt_after_drop", seg_cnt, exp_seg);

        // bad queue index, then a header-only segment
        exp_err.push_back(2'd3);
        send_hdr(4'd5, 16'd64, 1'b0, 56'h3, 8'h3);
        send_word(rnd256(), 1'b0, 1'b1);
        rh = {$urandom(), 24'($urandom())}; rc = 8'($urandom());
        exp_hdr.push_back('{rh, rc}); exp_seg++;
        send_hdr(4'd0, 16'd0, 1'b1, rh, rc);
        idle(3);
        chk("seg_cnt_len0", seg_cnt, exp_seg);

        // len 0 without eop; len 64 with eop on header; stray non-sop word in IDLE
        exp_err.push_back(2'd1);
        send_hdr(4'd1, 16'd0, 1'b0, 56'h4, 8'h4);
        send_word(rnd256(), 1'b0, 1'b1);
        exp_err.push_back(2'd1);
        send_hdr(4'd1, 16'd64, 1'b1, 56'h5, 8'h5);
        send_word(rnd256(), 1'b0, 1'b0);
        idle(3);
        chk("seg_cnt_len_errs", seg_cnt, exp_seg);

        // reset mid-segment: no error pulse, parser waits for next sop
        send_hdr(4'd1, 16'd96, 1'b0, 56'h6, 8'h6);
        send_pay(4'd1, 1, 1'b0);
        idle(2);
        rst_n = 1'b0;
        idle(2);
        chk("midrst_rx_ready", rx_ready, 1'b0);
        chk("midrst_seg_cnt", seg_cnt, '0);
        rst_n = 1'b1;
        exp_seg = '0;
        send_word(rnd256(), 1'b0, 1'b1);
        rh = {$urandom(), 24'($urandom())}; rc = 8'($urandom());
        exp_hdr.push_back('{rh, rc}); exp_seg++;
        send_hdr(4'd0, 16'd40, 1'b0, rh, rc);
        send_pay(4'd0, 2, 1'b1);
        idle(3);
        chk("seg_cnt_after_rst", seg_cnt, exp_seg);

        // header slot backpressure and counter wrap
        rdmap_ready = 1'b0;
        seg_ld = 1'b1; seg_ld_dat = 16'hFFFF;
        @(negedge clk);
        #1;
        seg_ld = 1'b0;
        exp_seg = 16'hFFFF;
        chk("seg_cnt_preload", seg_cnt, exp_seg);
        rh_a = {$urandom(), 24'($urandom())}; rc_a = 8'($urandom());
        rh_b = {$urandom(), 24'($urandom())}; rc_b = 8'($urandom());
        exp_hdr.push_back('{rh_a, rc_a}); exp_seg++;
        send_hdr(4'd0, 16'd0, 1'b1, rh_a, rc_a);
        idle(2);
        chk("seg_cnt_wrap", seg_cnt, exp_seg);
        chk("hdr_valid_held", hdr_valid, 1'b1);
        exp_hdr.push_back('{rh_b, rc_b}); exp_seg++;
        start_word(mk_hdr(4'd1, 16'd0, rh_b, rc_b), 1'b1, 1'b1);
        #1;
        low = 0;
        for (int i = 0; i < 4; i++) begin
            if (!rx_ready) low++;
            @(negedge clk);
            #1;
        end
        chk("hdr_bp_low_cycles", low, 4);
        chk("hdr_hold_data", hdr_out, rh_a);
        chk("hdr_hold_ctrl", ctrl_out, rc_a);
        rdmap_ready = 1'b1;
        finish_word();
        idle(4);
        chk("seg_cnt_second", seg_cnt, exp_seg);

        idle(3);
        chk("push_queue_drained", exp_push.size(), 0);
        chk("err_queue_drained", exp_err.size(), 0);
        chk("hdr_queue_drained", exp_hdr.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
